dice_turn_controller: RTL and testbench

//  Game sequencer downstream of the colour detector. Arms detection per turn,

---
 rtl/dice_game_pkg.sv | 37 +++
 rtl/dice_turn_controller_param_check.sv | 16 +
 rtl/dice_turn_controller_tick_divider.sv | 44 ++++
 rtl/dice_turn_controller.sv | 208 ++++++++++++++++++++
 tb/tb_dice_turn_controller.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dice_game_pkg.sv
// Shared types and helpers for the dice game sequencer.
//   state_t          : sequencer states, encoded 0..5 for the overlay
//   color_t          : dice colour codes as produced by the colour detector
//   color_to_steps() : maps a dice colour to the number of squares to move
package dice_game_pkg;

    localparam int POS_W = 5;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CLEAR     = 3'd1,
        WAIT_ROLL = 3'd2,
        MOVE      = 3'd3,
        WAIT_END  = 3'd4,
        WIN       = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        COLOR_NONE  = 2'b00,
        COLOR_RED   = 2'b01,
        COLOR_GREEN = 2'b10,
        COLOR_BLUE  = 2'b11
    } color_t;

    // RED=1, GREEN=2, BLUE=3 squares; NONE never starts a move.
    function automatic logic [1:0] color_to_steps(input logic [1:0] color);
        logic [1:0] steps;
        case (color)
            COLOR_RED:   steps = 2'd1;
            COLOR_GREEN: steps = 2'd2;
            COLOR_BLUE:  steps = 2'd3;
            default:     steps = 2'd0;
        endcase
        return steps;
    endfunction

endpackage

// File: rtl/dice_turn_controller_param_check.sv
// Elaboration-time parameter checks for dice_turn_controller.
// No ports; instantiated by the top purely so the checks elaborate with it.
module dice_turn_controller_param_check #(
    parameter int NUM_PLAYERS = 2,
    parameter int TRACK_LEN   = 20
);

    if (TRACK_LEN > 31 || TRACK_LEN < 1) begin : g_track_len_bad
        $error("dice_turn_controller: TRACK_LEN must be in 1..31 for 5-bit positions");
    end

    if (NUM_PLAYERS < 2 || NUM_PLAYERS > 4) begin : g_num_players_bad
        $error("dice_turn_controller: NUM_PLAYERS must be in 2..4");
    end

endmodule

// File: rtl/dice_turn_controller_tick_divider.sv
// tick_divider: enable counter that raises tick on the cycle it wraps from
// DIV-1 back to 0. Counting restarts from 0 whenever clear is high.
//   clk    in  system clock
//   reset  in  synchronous, active-high
//   clear  in  force the count back to 0
//   enable in  advance the count this cycle
//   tick   out high in the cycle the count wraps (decoded from the register)
module tick_divider #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_r;

    // Wrap counter: reset/clear to 0, advance while enabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (enable) begin
            if (cnt_r == CNT_LAST) begin
                cnt_r <= {CNT_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Kept combinational so the consumer can register its reaction on the
    // same edge the count wraps, giving exactly DIV cycles per tick.
    assign tick = enable && (cnt_r == CNT_LAST);

endmodule

// File: rtl/dice_turn_controller.sv
// dice_turn_controller: turn sequencer downstream of the colour detector.
// Arms detection for each turn, turns a stable dice colour into a step count,
// animates the active token one square per STEP_DELAY cycles, waits for a
// white-background turn_end before handing over, and declares a winner on
// reaching TRACK_LEN. All outputs are registered.
//   clk, reset     clock and synchronous active-high reset
//   start          level; rising edge starts/restarts a game
//   result_ready   pulse; stable_color valid
//   stable_color   00 NONE, 01 RED, 10 GREEN, 11 BLUE
//   turn_end       pulse; white background confirmed
//   white_level    level; detector sees white now
//   detect_arm     high while a dice result is accepted
//   cur_player     active player index
//   pos_flat       packed positions, player i at [5i +: 5]
//   steps_left     squares remaining in the current move
//   move_tick      1-cycle pulse per square advanced
//   game_state     state_t encoding
//   winner_valid   level, game over
//   winner_id      winning player index
//   timeout_flag   1-cycle pulse on a forfeited turn
module dice_turn_controller
    import dice_game_pkg::*;
#(
    parameter int NUM_PLAYERS  = 2,
    parameter int TRACK_LEN    = 20,
    parameter int STEP_DELAY   = 12_500_000,
    parameter int ROLL_TIMEOUT = 250_000_000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         result_ready,
    input  logic [1:0]                   stable_color,
    input  logic                         turn_end,
    input  logic                         white_level,
    output logic                         detect_arm,
    output logic [1:0]                   cur_player,
    output logic [NUM_PLAYERS*POS_W-1:0] pos_flat,
    output logic [1:0]                   steps_left,
    output logic                         move_tick,
    output logic [2:0]                   game_state,
    output logic                         winner_valid,
    output logic [1:0]                   winner_id,
    output logic                         timeout_flag
);

    localparam int PF_W = NUM_PLAYERS * POS_W;
    localparam int TO_W = (ROLL_TIMEOUT > 1) ? $clog2(ROLL_TIMEOUT) : 1;
    localparam logic [TO_W-1:0]  TO_LAST     = TO_W'(ROLL_TIMEOUT - 1);
    localparam logic [POS_W-1:0] TRACK_POS   = POS_W'(TRACK_LEN);
    localparam logic [1:0]       LAST_PLAYER = 2'(NUM_PLAYERS - 1);

    dice_turn_controller_param_check #(
        .NUM_PLAYERS (NUM_PLAYERS),
        .TRACK_LEN   (TRACK_LEN)
    ) u_param_check ();

    state_t            state_r, state_next_s;
    logic              start_d_r;
    logic              start_edge_s;
    logic [TO_W-1:0]   to_cnt_r, to_cnt_next_s;
    logic [1:0]        cur_player_r, cur_next_s;
    logic [PF_W-1:0]   pos_r, pos_next_s;
    logic [1:0]        steps_left_r, steps_next_s;
    logic              move_tick_r, tick_next_s;
    logic              timeout_flag_r, to_flag_next_s;
    logic              detect_arm_r, winner_valid_r;
    logic [1:0]        winner_id_r;
    logic [POS_W-1:0]  cur_pos_s, pos_inc_s;
    logic [1:0]        player_adv_s;
    logic              in_move_s, step_wrap_s;

    assign start_edge_s = start && !start_d_r;
    assign in_move_s    = (state_r == MOVE);
    assign cur_pos_s    = pos_r[POS_W*int'(cur_player_r) +: POS_W];
    assign pos_inc_s    = cur_pos_s + 5'd1;
    assign player_adv_s = (cur_player_r == LAST_PLAYER) ? 2'd0 : (cur_player_r + 2'd1);

    tick_divider #(
        .DIV (STEP_DELAY)
    ) u_step_div (
        .clk    (clk),
        .reset  (reset),
        .clear  (!in_move_s),
        .enable (in_move_s),
        .tick   (step_wrap_s)
    );

    // Next-state and next-output decode; a start edge overrides every state.
    always_comb begin
        state_next_s   = state_r;
        cur_next_s     = cur_player_r;
        pos_next_s     = pos_r;
        steps_next_s   = steps_left_r;
        tick_next_s    = 1'b0;
        to_flag_next_s = 1'b0;
        to_cnt_next_s  = {TO_W{1'b0}};
        if (start_edge_s) begin
            state_next_s = CLEAR;
            cur_next_s   = 2'd0;
            pos_next_s   = {PF_W{1'b0}};
            steps_next_s = 2'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    state_next_s = IDLE;
                end
                CLEAR: begin
                    if (white_level) begin
                        state_next_s = WAIT_ROLL;
                    end else begin
                        state_next_s = CLEAR;
                    end
                end
                WAIT_ROLL: begin
                    // A valid result beats both turn_end and a timeout in the same cycle.
                    if (result_ready && (stable_color != COLOR_NONE)) begin
                        steps_next_s = color_to_steps(stable_color);
                        state_next_s = MOVE;
                    end else if (to_cnt_r == TO_LAST) begin
                        to_flag_next_s = 1'b1;
                        cur_next_s     = player_adv_s;
                        state_next_s   = CLEAR;
                    end else begin
                        to_cnt_next_s = to_cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
                    end
                end
                MOVE: begin
                    if (step_wrap_s) begin
                        if (cur_pos_s < TRACK_POS) begin
                            pos_next_s[POS_W*int'(cur_player_r) +: POS_W] = pos_inc_s;
                            tick_next_s = 1'b1;
                        end else begin
                            tick_next_s = 1'b0;
                        end
                        // Reaching the finish square ends the game and drops remaining steps.
                        if (pos_inc_s >= TRACK_POS) begin
                            steps_next_s = 2'd0;
                            state_next_s = WIN;
                        end else if (steps_left_r <= 2'd1) begin
                            steps_next_s = 2'd0;
                            state_next_s = WAIT_END;
                        end else begin
                            steps_next_s = steps_left_r - 2'd1;
                            state_next_s = MOVE;
                        end
                    end else begin
                        state_next_s = MOVE;
                    end
                end
                WAIT_END: begin
                    if (turn_end) begin
                        cur_next_s   = player_adv_s;
                        state_next_s = WAIT_ROLL;
                    end else begin
                        state_next_s = WAIT_END;
                    end
                end
                WIN: begin
                    state_next_s = WIN;
                end
                default: begin
                    state_next_s = IDLE;
                end
            endcase
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= IDLE;
            start_d_r      <= 1'b0;
            to_cnt_r       <= {TO_W{1'b0}};
            cur_player_r   <= 2'd0;
            pos_r          <= {PF_W{1'b0}};
            steps_left_r   <= 2'd0;
            move_tick_r    <= 1'b0;
            timeout_flag_r <= 1'b0;
            detect_arm_r   <= 1'b0;
            winner_valid_r <= 1'b0;
            winner_id_r    <= 2'd0;
        end else begin
            state_r        <= state_next_s;
            start_d_r      <= start;
            to_cnt_r       <= to_cnt_next_s;
            cur_player_r   <= cur_next_s;
            pos_r          <= pos_next_s;
            steps_left_r   <= steps_next_s;
            move_tick_r    <= tick_next_s;
            timeout_flag_r <= to_flag_next_s;
            detect_arm_r   <= (state_next_s == WAIT_ROLL);
            winner_valid_r <= (state_next_s == WIN);
            winner_id_r    <= (state_next_s == WIN) ? cur_next_s : 2'd0;
        end
    end

    assign detect_arm   = detect_arm_r;
    assign cur_player   = cur_player_r;
    assign pos_flat     = pos_r;
    assign steps_left   = steps_left_r;
    assign move_tick    = move_tick_r;
    assign game_state   = state_r;
    assign winner_valid = winner_valid_r;
    assign winner_id    = winner_id_r;
    assign timeout_flag = timeout_flag_r;

endmodule

// File: tb/tb_dice_turn_controller.sv
// Directed self-checking bench for dice_turn_controller with a small game:
// STEP_DELAY=4, ROLL_TIMEOUT=50, TRACK_LEN=6, NUM_PLAYERS=2.
module tb_dice_turn_controller;

    localparam int NP = 2;
    localparam int SD = 4;
    localparam int RT = 50;
    localparam int TL = 6;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_CLEAR     = 3'd1;
    localparam logic [2:0] S_WAIT_ROLL = 3'd2;
    localparam logic [2:0] S_MOVE      = 3'd3;
    localparam logic [2:0] S_WAIT_END  = 3'd4;
    localparam logic [2:0] S_WIN       = 3'd5;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic            result_ready = 1'b0;
    logic [1:0]      stable_color = 2'b00;
    logic            turn_end = 1'b0;
    logic            white_level = 1'b0;
    logic            detect_arm;
    logic [1:0]      cur_player;
    logic [NP*5-1:0] pos_flat;
    logic [1:0]      steps_left;
    logic            move_tick;
    logic [2:0]      game_state;
    logic            winner_valid;
    logic [1:0]      winner_id;
    logic            timeout_flag;

    int checks_cnt = 0;
    int fail_cnt   = 0;

    dice_turn_controller #(
        .NUM_PLAYERS  (NP),
        .TRACK_LEN    (TL),
        .STEP_DELAY   (SD),
        .ROLL_TIMEOUT (RT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .result_ready (result_ready),
        .stable_color (stable_color),
        .turn_end     (turn_end),
        .white_level  (white_level),
        .detect_arm   (detect_arm),
        .cur_player   (cur_player),
        .pos_flat     (pos_flat),
        .steps_left   (steps_left),
        .move_tick    (move_tick),
        .game_state   (game_state),
        .winner_valid (winner_valid),
        .winner_id    (winner_id),
        .timeout_flag (timeout_flag)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_result(input logic [1:0] color);
        result_ready = 1'b1;
        stable_color = color;
        step();
        result_ready = 1'b0;
        stable_color = 2'b00;
    endtask

    task automatic pulse_turn_end();
        turn_end = 1'b1;
        step();
        turn_end = 1'b0;
    endtask

    // Roll and run the move out, counting move_tick pulses; bounded wait.
    task automatic play_move(input logic [1:0] color, output int ticks);
        int guard;
        ticks = 0;
        guard = 0;
        pulse_result(color);
        while (game_state == S_MOVE && guard < 40) begin
            step();
            if (move_tick) ticks++;
            guard++;
        end
        if (guard >= 40) check_eq("move_bound", 32'(game_state), 32'(S_WAIT_END));
    endtask

    initial begin
        int ticks;
        int pulses;

        // Reset state
        steps_n(2);
        reset = 1'b0;
        step();
        check_eq("rst_state", 32'(game_state), 32'(S_IDLE));
        check_eq("rst_outs", {detect_arm, cur_player, steps_left, move_tick, winner_valid,
                              winner_id, timeout_flag}, 32'd0);
        check_eq("rst_pos", 32'(pos_flat), 32'd0);

        // 1: start, white, green -> two ticks four cycles apart
        start = 1'b1;
        step();
        start = 1'b0;
        check_eq("t1_clear", 32'(game_state), 32'(S_CLEAR));
        step();
        check_eq("t1_clear_hold", 32'(game_state), 32'(S_CLEAR));
        white_level = 1'b1;
        step();
        check_eq("t1_wait_roll", 32'(game_state), 32'(S_WAIT_ROLL));
        check_eq("t1_armed", 32'(detect_arm), 32'd1);
        pulse_result(2'b10);
        check_eq("t1_move", 32'(game_state), 32'(S_MOVE));
        check_eq("t1_disarm", 32'(detect_arm), 32'd0);
        check_eq("t1_steps2", 32'(steps_left), 32'd2);
        steps_n(3);
        check_eq("t1_no_tick_early", 32'(move_tick), 32'd0);
        step();
        check_eq("t1_tick1", 32'(move_tick), 32'd1);
        check_eq("t1_pos1", 32'(pos_flat), 32'd1);
        check_eq("t1_steps1", 32'(steps_left), 32'd1);
        steps_n(3);
        check_eq("t1_no_tick_mid", 32'(move_tick), 32'd0);
        step();
        check_eq("t1_tick2", 32'(move_tick), 32'd1);
        check_eq("t1_pos2", 32'(pos_flat), 32'd2);
        check_eq("t1_wait_end", 32'(game_state), 32'(S_WAIT_END));

        // 4a: result during WAIT_END ignored
        pulse_result(2'b11);
        check_eq("t4_we_pos", 32'(pos_flat), 32'd2);
        check_eq("t4_we_state", 32'(game_state), 32'(S_WAIT_END));
        check_eq("t4_we_steps", 32'(steps_left), 32'd0);
        pulse_turn_end();
        check_eq("t1_next_player", 32'(cur_player), 32'd1);
        check_eq("t1_rearm", 32'(detect_arm), 32'd1);

        // 4b: colour NONE keeps the arm up
        pulse_result(2'b00);
        check_eq("t4_none_state", 32'(game_state), 32'(S_WAIT_ROLL));
        check_eq("t4_none_armed", 32'(detect_arm), 32'd1);

        // 5: result and turn_end together -> move taken
        result_ready = 1'b1;
        stable_color = 2'b01;
        turn_end = 1'b1;
        step();
        result_ready = 1'b0;
        stable_color = 2'b00;
        turn_end = 1'b0;
        check_eq("t5_move", 32'(game_state), 32'(S_MOVE));
        check_eq("t5_steps", 32'(steps_left), 32'd1);
        check_eq("t5_player", 32'(cur_player), 32'd1);
        // 4c: result during MOVE ignored
        pulse_result(2'b11);
        check_eq("t4_mv_steps", 32'(steps_left), 32'd1);
        check_eq("t4_mv_pos", 32'(pos_flat), 32'd2);
        steps_n(2);
        check_eq("t5_no_tick", 32'(move_tick), 32'd0);
        step();
        check_eq("t5_tick", 32'(move_tick), 32'd1);
        check_eq("t5_pos", 32'(pos_flat), 32'd34);
        check_eq("t5_wait_end", 32'(game_state), 32'(S_WAIT_END));
        pulse_turn_end();
        check_eq("t5_p0", 32'(cur_player), 32'd0);

        // 3: timeout after 50 cycles in WAIT_ROLL
        white_level = 1'b0;
        pulses = 0;
        for (int i = 0; i < 49; i++) begin
            step();
            if (timeout_flag) pulses++;
        end
        check_eq("t3_early_pulse", 32'(pulses), 32'd0);
        check_eq("t3_still_wait", 32'(game_state), 32'(S_WAIT_ROLL));
        step();
        check_eq("t3_flag", 32'(timeout_flag), 32'd1);
        check_eq("t3_clear", 32'(game_state), 32'(S_CLEAR));
        check_eq("t3_player", 32'(cur_player), 32'd1);
        check_eq("t3_disarm", 32'(detect_arm), 32'd0);
        step();
        check_eq("t3_flag_once", 32'(timeout_flag), 32'd0);

        // 2: play to the finish; P0 5 -> 6 wins after one tick
        white_level = 1'b1;
        step();
        play_move(2'b01, ticks);
        pulse_turn_end();
        play_move(2'b11, ticks);
        check_eq("t2_p0_at5", 32'(pos_flat), 32'd69);
        pulse_turn_end();
        play_move(2'b01, ticks);
        pulse_turn_end();
        play_move(2'b11, ticks);
        check_eq("t2_one_tick", 32'(ticks), 32'd1);
        check_eq("t2_pos", 32'(pos_flat), 32'd102);
        check_eq("t2_win", 32'(game_state), 32'(S_WIN));
        check_eq("t2_wvalid", 32'(winner_valid), 32'd1);
        check_eq("t2_wid", 32'(winner_id), 32'd0);
        check_eq("t2_steps", 32'(steps_left), 32'd0);
        pulse_result(2'b10);
        pulse_turn_end();
        steps_n(SD + 1);
        check_eq("t2_hold_pos", 32'(pos_flat), 32'd102);
        check_eq("t2_hold_win", {29'd0, winner_valid, winner_id}, 32'd4);
        check_eq("t2_hold_state", 32'(game_state), 32'(S_WIN));

        // 6a: start edge from WIN and mid-MOVE clears the game
        start = 1'b1;
        step();
        start = 1'b0;
        check_eq("t6_restart_win", {29'd0, winner_valid, winner_id}, 32'd0);
        check_eq("t6_restart_pos", 32'(pos_flat), 32'd0);
        step();
        pulse_result(2'b10);
        steps_n(SD + 1);
        check_eq("t6_mid_pos", 32'(pos_flat), 32'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        check_eq("t6_start_state", 32'(game_state), 32'(S_CLEAR));
        check_eq("t6_start_pos", 32'(pos_flat), 32'd0);
        check_eq("t6_start_steps", 32'(steps_left), 32'd0);

        // 6b: reset mid-MOVE
        step();
        pulse_result(2'b11);
        steps_n(SD + 1);
        check_eq("t6_pre_rst_state", 32'(game_state), 32'(S_MOVE));
        reset = 1'b1;
        step();
        check_eq("t6_rst_state", 32'(game_state), 32'(S_IDLE));
        check_eq("t6_rst_outs", {detect_arm, cur_player, steps_left, move_tick, winner_valid,
                                 winner_id, timeout_flag}, 32'd0);
        check_eq("t6_rst_pos", 32'(pos_flat), 32'd0);
        reset = 1'b0;
        steps_n(2);
        check_eq("t6_idle_hold", 32'(game_state), 32'(S_IDLE));

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
